// File: rtl/ivl_uvm_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ivl_uvm_arb_pkg
// Shared definitions for the round-robin arbiter slice: the arbiter FSM state
// type and the default values of the WIDTH and MAX_HOLD parameters.
// No ports (package).
// ---------------------------------------------------------------------------
package ivl_uvm_arb_pkg;

  // Default number of requesters (legal 2..16).
  localparam int DEF_WIDTH    = 4;
  // Default maximum grant tenure in clock cycles (legal 1..255).
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : ivl_uvm_arb_pkg

// File: rtl/ivl_uvm_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// ivl_uvm_rr_arbiter_if
// Request/grant bundle between the requester side and the arbiter.
//   en        : arbitration enable            (master -> slave)
//   req       : request vector, bit i = req i (master -> slave)
//   gnt       : registered zero-or-one-hot grant (slave -> master)
//   gnt_valid : high exactly when gnt is non-zero (slave -> master)
//   gnt_idx   : index of the granted bit, 0 when idle (slave -> master)
// Modports: master (requester side), slave (arbiter).
// ---------------------------------------------------------------------------
interface ivl_uvm_rr_arbiter_if
  import ivl_uvm_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IW = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] gnt;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_idx;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_idx
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_idx
  );

endinterface : ivl_uvm_rr_arbiter_if

// File: rtl/ivl_uvm_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// ivl_uvm_rr_pick
// Purely combinational round-robin selector: finds the first set request bit
// at or above ptr_i, wrapping around past WIDTH-1 to 0.
//   req_i    : request vector
//   ptr_i    : search start index (always < WIDTH)
//   onehot_o : one-hot of the selected requester, 0 when none
//   idx_o    : index of the selected requester, 0 when none
//   found_o  : at least one request bit set
// ---------------------------------------------------------------------------
module ivl_uvm_rr_pick
  import ivl_uvm_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]         req_i,
  input  logic [$clog2(WIDTH)-1:0] ptr_i,
  output logic [WIDTH-1:0]         onehot_o,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     found_o
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW:0] W_L = (IW+1)'(WIDTH);

  logic [WIDTH-1:0] rot;
  logic [IW-1:0]    k;
  logic [IW:0]      sum;

  always_comb begin
    // Rotate so that bit ptr_i lands at position 0; the doubled vector
    // supplies the wrapped-around bits.
    rot     = WIDTH'({req_i, req_i} >> ptr_i);
    found_o = |rot;
    k       = '0;
    // Descending scan leaves the lowest set bit in k.
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (rot[i]) k = IW'(i);
    end
    // Rotate back: (k + ptr) mod WIDTH.
    sum = {1'b0, k} + {1'b0, ptr_i};
    if (sum >= W_L) sum = sum - W_L;
    idx_o    = found_o ? sum[IW-1:0] : '0;
    onehot_o = found_o ? (WIDTH'(1) << idx_o) : '0;
  end

endmodule : ivl_uvm_rr_pick

// File: rtl/ivl_uvm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ivl_uvm_rr_arbiter
// Round-robin arbiter with bounded grant tenure. A grant is held while its
// requester keeps req high, up to MAX_HOLD cycles, then rotates to the next
// pending requester. All outputs are registered.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset, priority over everything
//   bus : ivl_uvm_rr_arbiter_if.slave (en, req in; gnt, gnt_valid, gnt_idx out)
// ---------------------------------------------------------------------------
module ivl_uvm_rr_arbiter
  import ivl_uvm_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                clk,
  input  logic                rst,
  ivl_uvm_rr_arbiter_if.slave bus
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(MAX_HOLD+1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q,   ptr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] gnt_q,   gnt_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic             vld_q,   vld_d;

  logic [WIDTH-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             hold;

  // ptr_q always points one past the last grant, so a release or a tenure
  // expiry searches the other requesters first and the holder comes last.
  ivl_uvm_rr_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;

    hold = (state_q == GRANT) && bus.req[idx_q] && (cnt_q < CW'(MAX_HOLD));

    if (!bus.en) begin
      // Disable drops the grant but keeps ptr for fairness.
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
      cnt_d   = '0;
    end else if (hold) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pick_found) begin
      // New grant (from IDLE, after release, or forced rotation).
      state_d = GRANT;
      gnt_d   = pick_onehot;
      idx_d   = pick_idx;
      vld_d   = 1'b1;
      cnt_d   = CW'(1);
      ptr_d   = (pick_idx == IW'(WIDTH-1)) ? '0 : pick_idx + IW'(1);
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;
  assign bus.gnt_idx   = idx_q;

endmodule : ivl_uvm_rr_arbiter

// File: tb/tb_ivl_uvm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ivl_uvm_rr_arbiter
// Self-checking bench: a behavioural round-robin model predicts the registered
// outputs for each driven cycle, the prediction is queued, and it is popped
// and compared once the DUT has taken the clock edge.
// ---------------------------------------------------------------------------
module tb_ivl_uvm_rr_arbiter;

  localparam int W  = 4;
  localparam int MH = 8;

  logic clk;
  logic rst;

  ivl_uvm_rr_arbiter_if #(.WIDTH(W)) bus ();

  ivl_uvm_rr_arbiter #(
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] gnt;
    logic         vld;
    logic [1:0]   idx;
    logic [1:0]   ptr;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  bit m_grant;
  int m_ptr;
  int m_cnt;
  int m_idx;
  logic [W-1:0] m_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int search(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      int j;
      j = (p + k) % W;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [W-1:0] q);
    int j;
    if (r) begin
      m_grant = 0; m_ptr = 0; m_cnt = 0; m_idx = 0; m_gnt = '0;
    end else if (!e) begin
      m_grant = 0; m_cnt = 0; m_idx = 0; m_gnt = '0;
    end else if (m_grant && q[m_idx] && m_cnt < MH) begin
      m_cnt++;
    end else begin
      j = search(q, m_ptr);
      if (j >= 0) begin
        m_grant = 1; m_idx = j; m_gnt = W'(1) << j; m_ptr = (j + 1) % W; m_cnt = 1;
      end else begin
        m_grant = 0; m_idx = 0; m_gnt = '0; m_cnt = 0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic [W-1:0] q);
    exp_t x;
    rst     = r;
    bus.en  = e;
    bus.req = q;
    model_step(r, e, q);
    x.gnt = m_gnt;
    x.vld = m_grant;
    x.idx = 2'(m_idx);
    x.ptr = 2'(m_ptr);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("gnt",     32'(bus.gnt),       32'(x.gnt));
      check("vld",     32'(bus.gnt_valid), 32'(x.vld));
      check("idx",     32'(bus.gnt_idx),   32'(x.idx));
      check("ptr",     32'(dut.ptr_q),     32'(x.ptr));
    end
    check("onehot0",   32'($onehot0(bus.gnt)), 32'd1);
    check("vld_eq_or", 32'(bus.gnt_valid),     32'(|bus.gnt));
  endtask

  logic [W-1:0] rq;
  logic         re, rr;

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = '0;

    // Reset state, even with requests pending.
    cycle(1'b1, 1'b1, 4'b1111);
    cycle(1'b1, 1'b0, 4'b0000);
    check("rst_gnt", 32'(bus.gnt), 32'd0);

    // Single requester 2 after reset.
    cycle(1'b0, 1'b1, 4'b0100);
    check("r030_gnt", 32'(bus.gnt),     32'h4);
    check("r030_idx", 32'(bus.gnt_idx), 32'd2);
    check("r030_ptr", 32'(dut.ptr_q),   32'd3);
    cycle(1'b0, 1'b1, 4'b0000);

    // All requesting: 8-cycle tenures rotating 0,1,2,3,0, no zero cycles.
    cycle(1'b1, 1'b1, 4'b0000);
    for (int c = 0; c < 4*MH + 2; c++) begin
      cycle(1'b0, 1'b1, 4'b1111);
      if (c == 0)      check("r031_first", 32'(bus.gnt), 32'h1);
      if (c == MH)     check("r031_second", 32'(bus.gnt), 32'h2);
      if (c == 3*MH)   check("r031_fourth", 32'(bus.gnt), 32'h8);
      if (c == 4*MH)   check("r031_wrap", 32'(bus.gnt), 32'h1);
    end

    // Holder 3 releases with only requester 0 pending: wrap-around.
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b1000);
    cycle(1'b0, 1'b1, 4'b0001);
    check("r032_wrap", 32'(bus.gnt), 32'h1);
    cycle(1'b0, 1'b1, 4'b0000);
    check("r032_idle", 32'(dut.state_q), 32'd0);

    // Lone requester held 20 cycles: continuous grant across reloads.
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b1, 4'b0010);
      check("r033_hold", 32'(bus.gnt), 32'h2);
    end
    cycle(1'b0, 1'b1, 4'b0000);

    // Reset mid-tenure, then fresh search from index 0.
    cycle(1'b0, 1'b1, 4'b0100);
    cycle(1'b0, 1'b1, 4'b0100);
    cycle(1'b1, 1'b1, 4'b0100);
    check("r034_rst", 32'(bus.gnt), 32'd0);
    cycle(1'b0, 1'b1, 4'b1010);
    check("r034_first", 32'(bus.gnt_idx), 32'd1);

    // Enable drop retains ptr.
    cycle(1'b1, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0001);
    cycle(1'b0, 1'b0, 4'b0001);
    check("r035_off", 32'(bus.gnt), 32'd0);
    cycle(1'b0, 1'b1, 4'b0011);
    check("r035_ptr", 32'(bus.gnt), 32'h2);

    // Random traffic with sticky requests, occasional disable and reset.
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rq = W'($urandom_range(0, 15));
      re = ($urandom_range(0, 19) != 0);
      rr = ($urandom_range(0, 59) == 0);
      cycle(rr, re, rq);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ivl_uvm_rr_arbiter

// File: doc/ivl_uvm_rr_arbiter.md
IVL_UVM_RR_ARBITER -- requirements
Module: ivl_uvm_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum grant tenure in clock cycles; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  arbitration enable.
REQ-006 req  input  WIDTH  request vector; bit i is requester i.
REQ-007 gnt  output  WIDTH  registered grant vector; always zero-or-one-hot.
REQ-008 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 gnt_idx  output  $clog2(WIDTH)  registered index of the granted bit; 0 when gnt_valid is low.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 IDLE, en=1, req non-zero: select the first set req bit, searching from ptr upward with wrap-around; next edge drives gnt to that one-hot value and enters GRANT. Latency is 1 cycle from req to gnt.
REQ-012 IDLE, en=0 or req=0: gnt, gnt_valid and gnt_idx remain 0.
REQ-013 On every new grant to index i, ptr SHALL load (i+1) mod WIDTH, and the tenure counter SHALL load 1.
REQ-014 GRANT: while req[gnt_idx]=1, en=1 and the tenure counter is below MAX_HOLD, gnt holds and the counter increments.
REQ-015 GRANT, req[gnt_idx]=0 (release): the same edge re-arbitrates over the current req using the updated ptr. With another requester pending, gnt moves directly to the new one-hot value with no zero cycle; otherwise gnt returns to 0 and the FSM returns to IDLE.
REQ-016 GRANT, tenure counter equal to MAX_HOLD with req[gnt_idx] still 1: forced rotation per REQ-015. The current holder is eligible only if no other requester is set, in which case it is re-granted and the counter reloads to 1.
REQ-017 en=0 in any state: the next edge drives gnt, gnt_valid and gnt_idx to 0 and the FSM to IDLE. ptr is retained.
REQ-018 Requests that rise while another requester holds the grant SHALL NOT preempt it.
REQ-019 Pointer arithmetic SHALL wrap modulo WIDTH; index WIDTH-1 wraps to 0.
REQ-020 The tenure counter SHALL be $clog2(MAX_HOLD+1) bits wide and SHALL never wrap.
REQ-021 gnt SHALL never have more than one bit set in any cycle, including reset and release cycles.
REQ-022 Every requester that holds req continuously SHALL be granted within (WIDTH-1)*MAX_HOLD+1 cycles.

Reset
REQ-023 With rst=1 at a rising edge: FSM goes to IDLE, gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, tenure counter=0.
REQ-024 rst has priority over en and req, including when asserted mid-tenure.
REQ-025 The first arbitration after reset SHALL start its search at index 0.

Structure
REQ-026 Package ivl_uvm_arb_pkg SHALL hold the state enum typedef (IDLE, GRANT) and the default values of WIDTH and MAX_HOLD.
REQ-027 Sub-module ivl_uvm_rr_pick SHALL be purely combinational: rotate req by ptr, find the first set bit, rotate back, and output a one-hot value plus index plus a found flag.
REQ-028 All outputs SHALL come directly from flops, with no combinational path from req to gnt.

Verification
REQ-029 The bench SHALL bind ovl_zero_one_hot (width=WIDTH) to gnt with enable 1'b1, and SHALL also check that gnt_valid equals |gnt every cycle. Any firing is a failure.
REQ-030 Reset release, req=4'b0100 -> one cycle later gnt=4'b0100, gnt_idx=2; ptr becomes 3.
REQ-031 req=4'b1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0, each for 8 cycles, with no zero-gnt cycle between them.
REQ-032 Holder 3 drops while req=4'b0001 -> next edge gnt=4'b0001 (wrap-around). Then req=0 -> gnt=0, FSM in IDLE.
REQ-033 Only req=4'b0010 held for 20 cycles -> gnt=4'b0010 continuously; the counter reloads at cycles 8 and 16.
REQ-034 Holder present and rst pulsed mid-tenure -> next edge all outputs 0. After release, req=4'b1010 grants index 1 first.
REQ-035 Holder present and en=0 for 1 cycle -> gnt=0. en=1 with req=4'b0011 and ptr=1 -> gnt=4'b0010.
